// File: rtl/queue_sched_pkg.sv
// Shared types and constants for the age-based queue scheduler.
package queue_sched_pkg;

  localparam int unsigned NUM_QUEUES_DEF     = 4;
  localparam int unsigned AGE_WIDTH_DEF      = 32;
  localparam int unsigned BURST_WIDTH_DEF    = 8;
  localparam int unsigned GRANT_ID_WIDTH_DEF = $clog2(NUM_QUEUES_DEF);

  typedef logic [GRANT_ID_WIDTH_DEF-1:0] grant_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SERVE  = 2'd1,
    ST_RETIRE = 2'd2
  } sched_state_e;

  // Saturation value of an age counter of the given width (widths up to 64).
  function automatic logic [63:0] age_max(input int unsigned width);
    if (width >= 64) begin
      age_max = '1;
    end else begin
      age_max = (64'd1 << width) - 64'd1;
    end
  endfunction

endpackage

// File: rtl/queue_age_scheduler_if.sv
// Request/grant bundle between the per-requester queues and the scheduler.
interface queue_age_scheduler_if
  import queue_sched_pkg::*;
#(
  parameter int unsigned NUMBER_OF_QUEUES = NUM_QUEUES_DEF,
  parameter int unsigned BURST_WIDTH      = BURST_WIDTH_DEF
);
  localparam int unsigned ID_W = $clog2(NUMBER_OF_QUEUES);

  logic [NUMBER_OF_QUEUES-1:0] empty;
  logic [BURST_WIDTH-1:0]      max_burst;
  logic                        beat_ready;
  logic [NUMBER_OF_QUEUES-1:0] pop;
  logic                        grant_valid;
  logic [ID_W-1:0]             grant_id;
  logic                        done;
  logic [BURST_WIDTH-1:0]      grant_beats;
  logic                        busy;

  modport master (
    output empty, max_burst, beat_ready,
    input  pop, grant_valid, grant_id, done, grant_beats, busy
  );

  modport slave (
    input  empty, max_burst, beat_ready,
    output pop, grant_valid, grant_id, done, grant_beats, busy
  );

endinterface

// File: rtl/oldest_select.sv
// Combinational argmax over requesting queues' ages; ties go to the lowest index.
module oldest_select #(
  parameter int unsigned NUMBER_OF_QUEUES = 4,
  parameter int unsigned AGE_WIDTH        = 32
) (
  input  logic [NUMBER_OF_QUEUES-1:0][AGE_WIDTH-1:0] i_age,
  input  logic [NUMBER_OF_QUEUES-1:0]                i_req,
  output logic [$clog2(NUMBER_OF_QUEUES)-1:0]        o_sel_c,
  output logic                                       o_any_valid_c
);
  localparam int unsigned ID_W = $clog2(NUMBER_OF_QUEUES);

  logic [AGE_WIDTH-1:0] w_best;
  logic [ID_W-1:0]      w_sel;
  logic                 w_found;

  // Strict greater-than keeps the earlier (lower) index on equal ages.
  always_comb begin
    w_best  = '0;
    w_sel   = '0;
    w_found = 1'b0;
    for (int unsigned q = 0; q < NUMBER_OF_QUEUES; q++) begin
      if (i_req[ID_W'(q)] && (!w_found || (i_age[ID_W'(q)] > w_best))) begin
        w_found = 1'b1;
        w_sel   = ID_W'(q);
        w_best  = i_age[ID_W'(q)];
      end
    end
    o_sel_c       = w_sel;
    o_any_valid_c = w_found;
  end

endmodule

// File: rtl/queue_age_scheduler.sv
// Age-based scheduler: grants the oldest non-empty queue one burst on the shared beat port.
module queue_age_scheduler
  import queue_sched_pkg::*;
#(
  parameter int unsigned NUMBER_OF_QUEUES = NUM_QUEUES_DEF,
  parameter int unsigned AGE_WIDTH        = AGE_WIDTH_DEF,
  parameter int unsigned BURST_WIDTH      = BURST_WIDTH_DEF
) (
  input logic                  i_clock,
  input logic                  i_reset,
  queue_age_scheduler_if.slave s_if
);
  localparam int unsigned ID_W = $clog2(NUMBER_OF_QUEUES);
  localparam logic [AGE_WIDTH-1:0] AGE_SAT = AGE_WIDTH'(age_max(AGE_WIDTH));

  sched_state_e r_state;
  sched_state_e w_state_next;

  logic [ID_W-1:0]                             r_grant_id;
  logic [BURST_WIDTH-1:0]                      r_remaining;
  logic [BURST_WIDTH-1:0]                      r_beats;
  logic [NUMBER_OF_QUEUES-1:0][AGE_WIDTH-1:0] r_age;
  logic                                        r_busy;
  logic                                        r_done;

  logic [NUMBER_OF_QUEUES-1:0] w_req;
  logic [NUMBER_OF_QUEUES-1:0] w_pop;
  logic [BURST_WIDTH-1:0]      w_burst_load;
  logic [ID_W-1:0]             w_sel_id;
  logic                        w_any_valid;
  logic                        w_pop_fire;

  assign w_req        = ~s_if.empty;
  assign w_burst_load = (s_if.max_burst == '0) ? BURST_WIDTH'(1) : s_if.max_burst;

  oldest_select #(
    .NUMBER_OF_QUEUES (NUMBER_OF_QUEUES),
    .AGE_WIDTH        (AGE_WIDTH)
  ) u_oldest_select (
    .i_age         (r_age),
    .i_req         (w_req),
    .o_sel_c       (w_sel_id),
    .o_any_valid_c (w_any_valid)
  );

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and live pop strobe
  always_comb begin
    w_state_next = r_state;
    w_pop        = '0;
    w_pop_fire   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_valid) begin
          w_state_next = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (s_if.empty[r_grant_id]) begin
          w_state_next = ST_RETIRE;
        end else if (s_if.beat_ready) begin
          w_pop_fire          = 1'b1;
          w_pop[r_grant_id]   = 1'b1;
          if (r_remaining == BURST_WIDTH'(1)) begin
            w_state_next = ST_RETIRE;
          end
        end
      end
      ST_RETIRE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Grant bookkeeping, status flags and the age array
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_grant_id  <= '0;
      r_remaining <= '0;
      r_beats     <= '0;
      r_age       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_busy <= (w_state_next != ST_IDLE);
      r_done <= (w_state_next == ST_RETIRE);
      case (r_state)
        ST_IDLE: begin
          if (w_any_valid) begin
            r_grant_id  <= w_sel_id;
            r_remaining <= w_burst_load;
            r_beats     <= '0;
          end
        end
        ST_SERVE: begin
          if (w_pop_fire) begin
            r_remaining <= r_remaining - BURST_WIDTH'(1);
            r_beats     <= r_beats + BURST_WIDTH'(1);
          end
        end
        ST_RETIRE: begin
          // Winner restarts at 1; waiting losers age, idle queues forget.
          for (int unsigned q = 0; q < NUMBER_OF_QUEUES; q++) begin
            if (ID_W'(q) == r_grant_id) begin
              r_age[ID_W'(q)] <= AGE_WIDTH'(1);
            end else if (!s_if.empty[ID_W'(q)]) begin
              if (r_age[ID_W'(q)] != AGE_SAT) begin
                r_age[ID_W'(q)] <= r_age[ID_W'(q)] + AGE_WIDTH'(1);
              end
            end else begin
              r_age[ID_W'(q)] <= '0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign s_if.pop         = w_pop;
  assign s_if.grant_valid = r_busy;
  assign s_if.busy        = r_busy;
  assign s_if.grant_id    = r_grant_id;
  assign s_if.done        = r_done;
  assign s_if.grant_beats = r_beats;

endmodule

// File: tb/tb_queue_age_scheduler.sv
// Bench for queue_age_scheduler: vector table, corner sequences and a random run vs a reference model.
module tb_queue_age_scheduler;
  import queue_sched_pkg::*;

  localparam int unsigned NQ  = 4;
  localparam int unsigned BW  = 8;
  localparam int unsigned AW0 = 32;
  localparam int unsigned AW1 = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NQ-1:0] empty;
  logic [BW-1:0] mb;
  logic          rdy;

  always #5 clk = ~clk;

  queue_age_scheduler_if #(.NUMBER_OF_QUEUES(NQ), .BURST_WIDTH(BW)) bus0 ();
  queue_age_scheduler_if #(.NUMBER_OF_QUEUES(NQ), .BURST_WIDTH(BW)) bus1 ();

  // Both instances see identical stimulus; bus1 uses narrow, quickly saturating ages.
  queue_age_scheduler #(.NUMBER_OF_QUEUES(NQ), .AGE_WIDTH(AW0), .BURST_WIDTH(BW)) dut (
    .i_clock (clk), .i_reset (rst), .s_if (bus0.slave));
  queue_age_scheduler #(.NUMBER_OF_QUEUES(NQ), .AGE_WIDTH(AW1), .BURST_WIDTH(BW)) dut_s (
    .i_clock (clk), .i_reset (rst), .s_if (bus1.slave));

  assign bus0.empty = empty;  assign bus0.max_burst = mb;  assign bus0.beat_ready = rdy;
  assign bus1.empty = empty;  assign bus1.max_burst = mb;  assign bus1.beat_ready = rdy;

  logic [NQ-1:0] a_pop [2];
  logic          a_gv  [2];
  logic          a_busy[2];
  logic          a_done[2];
  logic [1:0]    a_gid [2];
  logic [BW-1:0] a_gb  [2];
  logic [63:0]   a_age [2][NQ];

  always_comb begin
    a_pop[0] = bus0.pop;          a_pop[1] = bus1.pop;
    a_gv[0]  = bus0.grant_valid;  a_gv[1]  = bus1.grant_valid;
    a_busy[0] = bus0.busy;        a_busy[1] = bus1.busy;
    a_done[0] = bus0.done;        a_done[1] = bus1.done;
    a_gid[0] = bus0.grant_id;     a_gid[1] = bus1.grant_id;
    a_gb[0]  = bus0.grant_beats;  a_gb[1]  = bus1.grant_beats;
  end

  for (genvar q = 0; q < NQ; q++) begin : g_age
    assign a_age[0][q] = 64'(dut.r_age[q]);
    assign a_age[1][q] = 64'(dut_s.r_age[q]);
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase 0 = waiting, 1 = draining a burst, 2 = retiring.
  int              m_phase[2];
  int              m_gid[2];
  int              m_rem[2];
  int              m_beats[2];
  longint unsigned m_age[2][NQ];
  longint unsigned m_sat[2];

  typedef struct {
    logic [NQ-1:0] empty;
    logic [BW-1:0] mb;
    logic          rdy;
    logic [NQ-1:0] pop;
    logic          gv;
    logic [1:0]    gid;
    logic          done;
    logic [BW-1:0] gb;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int oldest(input int k);
    longint unsigned best = 0;
    bit any = 1'b0;
    for (int q = 0; q < NQ; q++) begin
      if (!empty[2'(q)]) begin
        any = 1'b1;
        if (m_age[k][q] > best) best = m_age[k][q];
      end
    end
    if (!any) return -1;
    for (int q = 0; q < NQ; q++) begin
      if (!empty[2'(q)] && m_age[k][q] == best) return q;
    end
    return -1;
  endfunction

  function automatic logic [NQ-1:0] exp_pop(input int k);
    logic [NQ-1:0] e = '0;
    if (m_phase[k] == 1 && rdy && !empty[2'(m_gid[k])]) e[2'(m_gid[k])] = 1'b1;
    return e;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_phase[k] = 0; m_gid[k] = 0; m_rem[k] = 0; m_beats[k] = 0;
        for (int q = 0; q < NQ; q++) m_age[k][q] = 0;
      end else if (m_phase[k] == 0) begin
        int w;
        w = oldest(k);
        if (w >= 0) begin
          m_gid[k] = w; m_rem[k] = (mb == 0) ? 1 : int'(mb); m_beats[k] = 0; m_phase[k] = 1;
        end
      end else if (m_phase[k] == 1) begin
        if (empty[2'(m_gid[k])]) begin
          m_phase[k] = 2;
        end else if (rdy) begin
          m_beats[k]++; m_rem[k]--;
          if (m_rem[k] == 0) m_phase[k] = 2;
        end
      end else begin
        for (int q = 0; q < NQ; q++) begin
          if (q == m_gid[k]) m_age[k][q] = 1;
          else if (!empty[2'(q)]) m_age[k][q] = (m_age[k][q] >= m_sat[k]) ? m_sat[k] : m_age[k][q] + 1;
          else m_age[k][q] = 0;
        end
        m_phase[k] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("pop[%0d]", k), 64'(a_pop[k]), 64'(exp_pop(k)));
      chk($sformatf("grant_valid[%0d]", k), 64'(a_gv[k]), 64'(m_phase[k] != 0));
      chk($sformatf("busy[%0d]", k), 64'(a_busy[k]), 64'(m_phase[k] != 0));
      chk($sformatf("grant_id[%0d]", k), 64'(a_gid[k]), 64'(m_gid[k]));
      chk($sformatf("done[%0d]", k), 64'(a_done[k]), 64'(m_phase[k] == 2));
      if (m_phase[k] == 2) chk($sformatf("grant_beats[%0d]", k), 64'(a_gb[k]), 64'(m_beats[k]));
      for (int q = 0; q < NQ; q++) chk($sformatf("age[%0d][%0d]", k, q), a_age[k][q], m_age[k][q]);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check_all();
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  function automatic vec_t mkv(input logic [NQ-1:0] e, input int b, input logic r,
                               input logic [NQ-1:0] p, input logic v, input int g,
                               input logic d, input int n);
    vec_t x;
    x.empty = e; x.mb = BW'(b); x.rdy = r; x.pop = p; x.gv = v; x.gid = 2'(g); x.done = d; x.gb = BW'(n);
    return x;
  endfunction

  initial begin
    m_sat[0] = age_max(AW0);
    m_sat[1] = age_max(AW1);
    rst = 1'b1; empty = '1; mb = '0; rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_step();

    // Reset state
    sample();
    chk("rst_pop", 64'(bus0.pop), 64'(0));
    chk("rst_busy", 64'(bus0.busy), 64'(0));
    chk("rst_gid", 64'(bus0.grant_id), 64'(0));
    chk("rst_gb", 64'(bus0.grant_beats), 64'(0));
    chk("rst_done", 64'(bus0.done), 64'(0));
    advance();
    rst = 1'b0;

    // Single-queue burst of 3, then a backpressured burst of 4 whose max_burst changes mid-grant
    vt[0]  = mkv(4'b1101, 3, 1'b1, 4'b0000, 1'b0, 0, 1'b0, 0);
    for (int i = 1; i <= 3; i++) vt[i] = mkv(4'b1101, 3, 1'b1, 4'b0010, 1'b1, 1, 1'b0, 0);
    vt[4]  = mkv(4'b1101, 3, 1'b1, 4'b0000, 1'b1, 1, 1'b1, 3);
    vt[5]  = mkv(4'b1111, 3, 1'b1, 4'b0000, 1'b0, 1, 1'b0, 0);
    vt[6]  = mkv(4'b1011, 4, 1'b0, 4'b0000, 1'b0, 1, 1'b0, 0);
    for (int i = 7; i <= 11; i++) vt[i] = mkv(4'b1011, 4, 1'b0, 4'b0000, 1'b1, 2, 1'b0, 0);
    for (int i = 12; i <= 15; i++) vt[i] = mkv(4'b1011, 1, 1'b1, 4'b0100, 1'b1, 2, 1'b0, 0);
    vt[16] = mkv(4'b1011, 1, 1'b1, 4'b0000, 1'b1, 2, 1'b1, 4);
    vt[17] = mkv(4'b1111, 1, 1'b1, 4'b0000, 1'b0, 2, 1'b0, 0);

    for (int i = 0; i < 18; i++) begin
      empty = vt[i].empty; mb = vt[i].mb; rdy = vt[i].rdy;
      sample();
      chk($sformatf("vec%0d_pop", i), 64'(bus0.pop), 64'(vt[i].pop));
      chk($sformatf("vec%0d_gv", i), 64'(bus0.grant_valid), 64'(vt[i].gv));
      chk($sformatf("vec%0d_busy", i), 64'(bus0.busy), 64'(vt[i].gv));
      chk($sformatf("vec%0d_gid", i), 64'(bus0.grant_id), 64'(vt[i].gid));
      chk($sformatf("vec%0d_done", i), 64'(bus0.done), 64'(vt[i].done));
      if (vt[i].done) chk($sformatf("vec%0d_gb", i), 64'(bus0.grant_beats), 64'(vt[i].gb));
      if (i == 5) begin
        for (int q = 0; q < NQ; q++) chk($sformatf("vec5_age%0d", q), a_age[0][q], (q == 1) ? 64'd1 : 64'd0);
      end
      advance();
    end

    // Aging fairness: the initial tie goes to queue 0 twice, then grants alternate
    begin : fairness
      int ng;
      int exp_g[6];
      exp_g = '{0, 0, 2, 0, 2, 0};
      ng = 0;
      rst = 1'b1; step(); rst = 1'b0;
      empty = 4'b1010; mb = 8'd1; rdy = 1'b1;
      for (int c = 0; c < 60 && ng < 6; c++) begin
        sample();
        if (bus0.done) begin
          chk($sformatf("fair_gid%0d", ng), 64'(bus0.grant_id), 64'(exp_g[ng]));
          if (bus0.grant_id == 2'd2) chk($sformatf("fair_age2_%0d", ng), a_age[0][2], 64'd2);
          ng++;
        end
        advance();
      end
      chk("fair_grants", 64'(ng), 64'(6));
    end

    // Early drain after two pops of an 8-beat burst
    rst = 1'b1; step(); rst = 1'b0;
    empty = 4'b1110; mb = 8'd8; rdy = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      sample(); chk($sformatf("drain_pop%0d", i), 64'(bus0.pop), 64'(4'b0001)); advance();
    end
    empty = 4'b1111;
    sample(); chk("drain_nopop", 64'(bus0.pop), 64'(0)); chk("drain_busy", 64'(bus0.busy), 64'(1)); advance();
    sample(); chk("drain_done", 64'(bus0.done), 64'(1)); chk("drain_gb", 64'(bus0.grant_beats), 64'(2));
    chk("drain_pop_retire", 64'(bus0.pop), 64'(0)); advance();
    sample(); chk("drain_idle", 64'(bus0.busy), 64'(0)); chk("drain_age0", a_age[0][0], 64'd1); advance();

    // Reset after one pop of a 4-beat burst: aborted grant leaves no trace
    empty = 4'b1110; mb = 8'd4; rdy = 1'b1;
    step();
    sample(); chk("mid_pop", 64'(bus0.pop), 64'(4'b0001)); advance();
    rst = 1'b1; step(); rst = 1'b0;
    empty = 4'b1111;
    sample();
    chk("mid_busy", 64'(bus0.busy), 64'(0));
    chk("mid_pop_after", 64'(bus0.pop), 64'(0));
    for (int q = 0; q < NQ; q++) chk($sformatf("mid_age%0d", q), a_age[0][q], 64'd0);
    advance();
    for (int i = 0; i < 3; i++) begin
      sample(); chk($sformatf("mid_nodone%0d", i), 64'(bus0.done), 64'(0)); advance();
    end

    // Zero burst with all queues busy: 2-bit ages saturate and starve queue 3
    begin : saturation
      int nr;
      int exp_g[5];
      exp_g = '{0, 0, 1, 2, 0};
      nr = 0;
      rst = 1'b1; step(); rst = 1'b0;
      empty = 4'b0000; mb = 8'd0; rdy = 1'b1;
      for (int c = 0; c < 60 && nr < 5; c++) begin
        sample();
        if (bus0.done) chk($sformatf("zb_beats0_%0d", c), 64'(bus0.grant_beats), 64'(1));
        if (bus1.done) begin
          chk($sformatf("zb_beats1_%0d", nr), 64'(bus1.grant_beats), 64'(1));
          chk($sformatf("sat_gid%0d", nr), 64'(bus1.grant_id), 64'(exp_g[nr]));
          nr++;
        end
        advance();
      end
      chk("sat_retires", 64'(nr), 64'(5));
      sample(); chk("sat_age3", a_age[1][3], 64'd3); advance();
    end

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) empty = NQ'($urandom);
      mb  = ($urandom_range(0, 7) == 0) ? BW'($urandom) : BW'($urandom_range(0, 4));
      rdy = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/queue_age_scheduler.md
# queue_age_scheduler

- Control-side scheduler that shares one downstream beat port among NUMBER_OF_QUEUES request queues.
- Keeps a per-queue age counter and grants the non-empty queue with the oldest age.
- Drains the granted queue for up to a programmable burst, then ages the losers and resets the winner's age.
- Sits between the relational cache's per-requester FIFOs and the shared fetch/write datapath.

## Interface
- NUMBER_OF_QUEUES, 4, number of request queues (≥2)
- AGE_WIDTH, 32, width of each age counter
- BURST_WIDTH, 8, width of burst length and beat count
- clock  in  1  single clock; all logic rises on posedge
- reset  in  1  synchronous, active-high
- empty  in  NUMBER_OF_QUEUES  per-queue empty flag; queue i requests when empty[i]=0
- max_burst  in  BURST_WIDTH  beats per grant; 0 is treated as 1; sampled at grant
- beat_ready  in  1  downstream accepts one beat this cycle
- pop  out  NUMBER_OF_QUEUES  one-hot pop strobe to the granted queue
- grant_valid  out  1  a grant is active
- grant_id  out  $clog2(NUMBER_OF_QUEUES)  index of the granted queue
- done  out  1  single-cycle pulse when a grant retires
- grant_beats  out  BURST_WIDTH  beats popped in the retiring grant; valid while done=1
- busy  out  1  FSM is not in IDLE

## Operation
- FSM states: IDLE, SERVE, RETIRE.
- IDLE:
  - If any empty[i]=0, select the queue with the maximum age; ties go to the lowest index.
  - Register the selection into grant_id, load remaining=max(max_burst,1), clear the beat count, then go to SERVE.
  - If all queues are empty, stay in IDLE.
- SERVE:
  - pop[grant_id] = beat_ready & ~empty[grant_id]. All other pop bits are 0. pop is combinational from registered state and live inputs.
  - Each pop decrements remaining and increments the beat count.
  - Go to RETIRE when a pop occurs with remaining=1 (burst complete).
  - Also go to RETIRE when empty[grant_id]=1 (early drain end, no pop that cycle).
  - beat_ready=0 with a non-empty queue stalls in SERVE indefinitely.
- RETIRE (one cycle):
  - done=1 and grant_beats=beat count.
  - Age update: granted queue age ← 1.
  - Every other queue with empty=0 gets age+1, saturating at 2^AGE_WIDTH−1.
  - Every other queue with empty=1 gets age ← 0.
  - Next state is IDLE.
- Ages change only in RETIRE. Selection always uses registered ages.
- A grant that retires with 0 beats (queue empty on the first SERVE cycle) still performs the age update.

## Timing
- Reset values:
  - State IDLE.
  - All ages 0.
  - pop=0, grant_valid=0, grant_id=0, done=0, grant_beats=0, busy=0.
- Reset asserted mid-grant:
  - Next cycle the FSM is in IDLE and pop is 0.
  - No done pulse and no age update for the aborted grant.
- Request to grant: empty[i] falls in cycle t (FSM in IDLE), so grant_valid=1 and grant_id valid in t+1. The first pop is possible in t+1.
- grant_valid=busy=1 in SERVE and RETIRE. grant_id is stable for the whole grant.
- Back-to-back: the next grant_valid rises 2 cycles after the done cycle (RETIRE→IDLE→SERVE).
- Maximum throughput: one beat per cycle within a burst.
- max_burst is sampled only in IDLE on the grant decision. Changes mid-grant have no effect.

## Structure
- Shared package (queue_sched_pkg):
  - state enum {IDLE, SERVE, RETIRE}
  - AGE_MAX constant function
  - grant index type derived from NUMBER_OF_QUEUES
- Sub-module oldest_select: combinational argmax over ages, masked by ~empty, lowest-index tie-break. It outputs the index and an any_valid bit.
- Age array, beat counter and FSM stay in the top module.

## Test plan
- Single queue: reset, then empty=4'b1101, max_burst=3, beat_ready=1 held. Required: grant_id=1 one cycle later, pop=4'b0010 for exactly 3 cycles, done with grant_beats=3, then ages={0,1,0,0}.
- Aging fairness: queues 0 and 2 are always non-empty, max_burst=1. Required: grants alternate 0,2,0,2. The loser's age reaches 2 before winning, and ties resolve to queue 0 first.
- Early drain: max_burst=8, and empty[grant_id] rises after 2 pops. Required: the FSM goes to RETIRE, done with grant_beats=2, and no further pop.
- Backpressure: beat_ready=0 for 5 cycles mid-burst. Required: pop=0 and the FSM holds SERVE. The burst completes with the correct count once beat_ready returns.
- Saturation and zero burst: AGE_WIDTH=2, one queue starved over 5 retirements. Required: its age holds at 3. With max_burst=0, exactly 1 beat per grant.
- Reset mid-SERVE: assert reset after 1 pop of a 4-beat burst. Required: the next cycle has busy=0, pop=0, all ages 0, and no done pulse.
